// File: rtl/cryptoveril_pkg.sv
// Shared definitions for the cryptoveril decryptor.
// Contents:
//   DATA_W, KEY_W  fixed word and key widths (only 16 and 5 are supported)
//   dec_state_t    decryptor FSM states
//   expand_key     5-bit key -> 16-bit whitening word K16
//   rot_amt        5-bit key -> rotation amount r (0..15)
//   encrypt_ref    forward cipher, used to generate ciphertext for the decryptor
package cryptoveril_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned KEY_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        ROT  = 2'd2,
        XOR  = 2'd3
    } dec_state_t;

    function automatic logic [DATA_W-1:0] expand_key(input logic [KEY_W-1:0] key);
        return {key[0], key, key, key};
    endfunction

    function automatic logic [3:0] rot_amt(input logic [KEY_W-1:0] key);
        return key[3:0];
    endfunction

    // c = (rotl(p ^ K16, r) + K16) mod 2^16
    function automatic logic [DATA_W-1:0] encrypt_ref(input logic [DATA_W-1:0] p,
                                                      input logic [KEY_W-1:0]  key);
        logic [DATA_W-1:0]   k16;
        logic [DATA_W-1:0]   x;
        logic [2*DATA_W-1:0] dbl;
        k16 = expand_key(key);
        x   = p ^ k16;
        // Upper half of the doubled word shifted left is the left rotation.
        dbl = {x, x} << rot_amt(key);
        return dbl[2*DATA_W-1:DATA_W] + k16;
    endfunction

endpackage

// File: rtl/cryptoveril_decrypt_if.sv
// Handshake/data bundle between a cryptoveril word source and the decryptor.
//   key_bits, cipher_data  word and key to buffer on ld
//   ld, start              load buffers / begin decryption
//   busy, done             operation in progress / one-cycle completion pulse
//   plain_data             recovered plaintext, held until the next completion
// master: the side driving ld/start; slave: the decryptor.
interface cryptoveril_decrypt_if;
    import cryptoveril_pkg::*;

    logic [KEY_W-1:0]  key_bits;
    logic [DATA_W-1:0] cipher_data;
    logic              ld;
    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] plain_data;

    modport master (
        output key_bits, cipher_data, ld, start,
        input  busy, done, plain_data
    );

    modport slave (
        input  key_bits, cipher_data, ld, start,
        output busy, done, plain_data
    );

endinterface

// File: rtl/cryptoveril_rotr_serial.sv
// Serial right-rotator: a work register plus a rotation down-counter.
//   clk, rst   clock and synchronous active-high reset
//   load       capture load_val into work and load_cnt into the counter
//   load_val   initial work value
//   load_cnt   number of single-bit right rotations still to perform
//   step       rotate work right by one bit and decrement the counter
//   work       current work value
//   last       counter is 1: the current step is the final rotation
module cryptoveril_rotr_serial
    import cryptoveril_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic [3:0]        load_cnt,
    input  logic              step,
    output logic [DATA_W-1:0] work,
    output logic              last
);

    logic [DATA_W-1:0] work_q;
    logic [3:0]        cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            work_q <= load_val;
            cnt_q  <= load_cnt;
        end else if (step) begin
            work_q <= {work_q[0], work_q[DATA_W-1:1]};
            cnt_q  <= cnt_q - 4'd1;
        end
    end

    assign work = work_q;
    assign last = (cnt_q == 4'd1);

endmodule

// File: rtl/cryptoveril_decrypt.sv
// Cryptoveril decryptor: p = rotr((c - K16) mod 2^16, r) ^ K16.
// The rotation runs one bit per cycle, so an operation takes r+2 cycles from
// the start edge to the done pulse.
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of cryptoveril_decrypt_if (ld/start in, busy/done/plain_data out)
module cryptoveril_decrypt
    import cryptoveril_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cryptoveril_decrypt_if.slave bus
);

    dec_state_t        state_q, state_d;
    logic [DATA_W-1:0] cbuf_q;
    logic [KEY_W-1:0]  kbuf_q;
    logic              loaded_q;
    logic [DATA_W-1:0] plain_q;
    logic              done_q;

    logic [DATA_W-1:0] k16;
    logic [3:0]        r;
    logic              accept;
    logic              rot_load;
    logic              rot_step;
    logic [DATA_W-1:0] work;
    logic              rot_last;

    assign k16 = expand_key(kbuf_q);
    assign r   = rot_amt(kbuf_q);

    // With ld and start together the buffers fill on this edge and SUB reads them next cycle.
    assign accept = bus.start && (loaded_q || bus.ld);

    always_comb begin
        state_d  = state_q;
        rot_load = 1'b0;
        rot_step = 1'b0;
        unique case (state_q)
            IDLE: if (accept) state_d = SUB;
            SUB: begin
                rot_load = 1'b1;
                state_d  = (r != 4'd0) ? ROT : XOR;
            end
            ROT: begin
                rot_step = 1'b1;
                if (rot_last) state_d = XOR;
            end
            XOR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    cryptoveril_rotr_serial u_rotr (
        .clk      (clk),
        .rst      (rst),
        .load     (rot_load),
        .load_val (cbuf_q - k16),
        .load_cnt (r),
        .step     (rot_step),
        .work     (work),
        .last     (rot_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cbuf_q   <= '0;
            kbuf_q   <= '0;
            loaded_q <= 1'b0;
            plain_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == XOR);
            // Buffers only change in IDLE, so an operation in flight is isolated.
            if (state_q == IDLE && bus.ld) begin
                cbuf_q   <= bus.cipher_data;
                kbuf_q   <= bus.key_bits;
                loaded_q <= 1'b1;
            end
            if (state_q == XOR) begin
                plain_q  <= work ^ k16;
                loaded_q <= 1'b0;
            end
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.plain_data = plain_q;

endmodule
